// File: rtl/route_unit_xy.sv
// route_unit_xy
// Per-input-port route computation stage for a 2-D mesh router.
// A header flit's destination is decoded and turned into a dimension-ordered
// output port. That port is locked for the packet's body and tail flits.
// Each flit is then presented, registered, together with its port.
//
// Build option:
//   YX_ORDER_EN  - when defined, resolve the Y dimension first (YX routing);
//                  when undefined (default), resolve X first (XY routing).
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   in_flit/in_valid   upstream flit and its valid
//   in_ready           high when the output register can take a new flit
//   out_flit/out_valid registered flit and its valid
//   out_ready          downstream accepts the registered flit
//   out_port           port code: L=1 E=2 N=3 W=4 S=5, 0 = none
//   out_onehot         one-hot port: bit0 L, bit1 E, bit2 W, bit3 S, bit4 N
//   route_err          one-cycle pulse, aligned with the first cycle the
//                      offending flit appears on the output
module route_unit_xy #(
    parameter int X_NODE_NUM = 4,
    parameter int Y_NODE_NUM = 4,
    parameter int X_W        = 2,
    parameter int Y_W        = 2,
    parameter int CUR_X      = 0,
    parameter int CUR_Y      = 2,
    parameter int FLIT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [FLIT_W-1:0] in_flit,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [FLIT_W-1:0] out_flit,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        out_port,
    output logic [4:0]        out_onehot,
    output logic              route_err
);

    localparam logic [1:0] FT_BODY = 2'b00;
    localparam logic [1:0] FT_TAIL = 2'b01;
    localparam logic [1:0] FT_HDR  = 2'b10;
    localparam logic [1:0] FT_HT   = 2'b11;

    localparam logic [3:0] PORT_NONE = 4'd0;
    localparam logic [3:0] PORT_L    = 4'd1;
    localparam logic [3:0] PORT_E    = 4'd2;
    localparam logic [3:0] PORT_N    = 4'd3;
    localparam logic [3:0] PORT_W    = 4'd4;
    localparam logic [3:0] PORT_S    = 4'd5;

    // One extra bit so that the coordinate difference never overflows.
    localparam int D_W = ((X_W > Y_W) ? X_W : Y_W) + 1;
    localparam logic [D_W-1:0] CUR_X_V = D_W'(CUR_X);
    localparam logic [D_W-1:0] CUR_Y_V = D_W'(CUR_Y);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [3:0]               r_lock_port;
    logic [3:0]               w_lock_nxt;
    logic [FLIT_W-1:0]        r_flit;
    logic                     r_valid;
    logic [3:0]               r_port;
    logic [4:0]               r_onehot;
    logic                     r_err;

    logic                     w_accept;
    logic [1:0]               w_type;
    logic [X_W-1:0]           w_dest_x;
    logic [Y_W-1:0]           w_dest_y;
    logic signed [D_W-1:0]    w_dx;
    logic signed [D_W-1:0]    w_dy;
    logic                     w_in_mesh;
    logic [3:0]               w_route;
    logic [3:0]               w_port_nxt;
    logic                     w_err_nxt;

    // Dimension-ordered route from signed coordinate differences.
    function automatic logic [3:0] route_calc(input logic signed [D_W-1:0] dx,
                                              input logic signed [D_W-1:0] dy);
        logic dx_pos, dx_neg, dy_pos, dy_neg;
        dx_pos = !dx[D_W-1] && (dx != '0);
        dx_neg = dx[D_W-1];
        dy_pos = !dy[D_W-1] && (dy != '0);
        dy_neg = dy[D_W-1];
`ifdef YX_ORDER_EN
        if (dy_pos)      route_calc = PORT_S;
        else if (dy_neg) route_calc = PORT_N;
        else if (dx_pos) route_calc = PORT_E;
        else if (dx_neg) route_calc = PORT_W;
        else             route_calc = PORT_L;
`else
        if (dx_pos)      route_calc = PORT_E;
        else if (dx_neg) route_calc = PORT_W;
        else if (dy_pos) route_calc = PORT_S;
        else if (dy_neg) route_calc = PORT_N;
        else             route_calc = PORT_L;
`endif
    endfunction

    // Bit order of the one-hot vector differs from the port code order.
    function automatic logic [4:0] port_onehot(input logic [3:0] port);
        case (port)
            PORT_L:  port_onehot = 5'b00001;
            PORT_E:  port_onehot = 5'b00010;
            PORT_W:  port_onehot = 5'b00100;
            PORT_S:  port_onehot = 5'b01000;
            PORT_N:  port_onehot = 5'b10000;
            default: port_onehot = 5'b00000;
        endcase
    endfunction

    assign in_ready  = !r_valid || out_ready;
    assign w_accept  = in_valid && in_ready;

    assign w_type    = in_flit[FLIT_W-1:FLIT_W-2];
    assign w_dest_x  = in_flit[X_W-1:0];
    assign w_dest_y  = in_flit[X_W+Y_W-1:X_W];
    assign w_dx      = $signed({{(D_W-X_W){1'b0}}, w_dest_x}) - $signed(CUR_X_V);
    assign w_dy      = $signed({{(D_W-Y_W){1'b0}}, w_dest_y}) - $signed(CUR_Y_V);
    assign w_in_mesh = (32'(w_dest_x) < 32'(X_NODE_NUM)) &&
                       (32'(w_dest_y) < 32'(Y_NODE_NUM));
    assign w_route   = route_calc(w_dx, w_dy);

    always_comb begin
        w_state_nxt = r_state;
        w_lock_nxt  = r_lock_port;
        w_port_nxt  = PORT_NONE;
        w_err_nxt   = 1'b0;
        if (w_accept) begin
            case (w_type)
                FT_HDR, FT_HT: begin
                    if (!w_in_mesh) begin
                        // Unroutable header: flag it, keep state and lock.
                        w_err_nxt = 1'b1;
                    end else begin
                        w_port_nxt = w_route;
                        // A header arriving mid-packet means the previous tail was lost.
                        w_err_nxt  = (r_state == S_BUSY);
                        if (w_type == FT_HDR) begin
                            w_lock_nxt  = w_route;
                            w_state_nxt = S_BUSY;
                        end else begin
                            w_state_nxt = S_IDLE;
                        end
                    end
                end
                default: begin
                    if (r_state == S_BUSY) begin
                        w_port_nxt = r_lock_port;
                        if (w_type == FT_TAIL) begin
                            w_state_nxt = S_IDLE;
                        end
                    end else begin
                        // Orphan body/tail is still forwarded, but without a port.
                        w_err_nxt = 1'b1;
                    end
                end
            endcase
        end
    end

    // Output register stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_lock_port <= PORT_NONE;
            r_flit      <= '0;
            r_valid     <= 1'b0;
            r_port      <= PORT_NONE;
            r_onehot    <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_lock_port <= w_lock_nxt;
            r_err       <= w_err_nxt;
            if (w_accept) begin
                r_flit   <= in_flit;
                r_port   <= w_port_nxt;
                r_onehot <= port_onehot(w_port_nxt);
                r_valid  <= 1'b1;
            end else if (out_ready) begin
                r_valid  <= 1'b0;
            end
        end
    end

    assign out_flit   = r_flit;
    assign out_valid  = r_valid;
    assign out_port   = r_port;
    assign out_onehot = r_onehot;
    assign route_err  = r_err;

endmodule

// File: tb/tb_route_unit_xy.sv
// Testbench for route_unit_xy: directed packets and a randomized stream are
// checked by a queue-based scoreboard against a behavioural route model.
// A second instance with a 3-column mesh covers out-of-mesh destinations.
module tb_route_unit_xy;

    localparam int XN = 4;
    localparam int YN = 4;
    localparam int CX = 0;
    localparam int CY = 2;

    localparam logic [1:0] T_BODY = 2'b00;
    localparam logic [1:0] T_TAIL = 2'b01;
    localparam logic [1:0] T_HDR  = 2'b10;
    localparam logic [1:0] T_HT   = 2'b11;

    logic        clk;
    logic        rst_n;
    logic [15:0] in_flit;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out_flit;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_port;
    logic [4:0]  out_onehot;
    logic        route_err;

    logic [15:0] i3_flit;
    logic        i3_valid;
    logic        i3_ready;
    logic [15:0] o3_flit;
    logic        o3_valid;
    logic        o3_ready;
    logic [3:0]  o3_port;
    logic [4:0]  o3_onehot;
    logic        o3_err;

    route_unit_xy dut (
        .clk(clk), .rst_n(rst_n),
        .in_flit(in_flit), .in_valid(in_valid), .in_ready(in_ready),
        .out_flit(out_flit), .out_valid(out_valid), .out_ready(out_ready),
        .out_port(out_port), .out_onehot(out_onehot), .route_err(route_err)
    );

    route_unit_xy #(.X_NODE_NUM(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .in_flit(i3_flit), .in_valid(i3_valid), .in_ready(i3_ready),
        .out_flit(o3_flit), .out_valid(o3_valid), .out_ready(o3_ready),
        .out_port(o3_port), .out_onehot(o3_onehot), .route_err(o3_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nchk = 0;
    int nerr = 0;
    int cyc  = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: packet-in-progress flag plus the route of the open packet.
    typedef struct {
        logic [15:0] flit;
        logic [3:0]  port;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t       sbq[$];
    bit         m_busy = 1'b0;
    logic [3:0] m_lock = 4'd0;
    logic [4:0] oh_tab [0:7] = '{5'd0, 5'd1, 5'd2, 5'd16, 5'd4, 5'd8, 5'd0, 5'd0};

    function automatic logic [3:0] ref_route(input int x, input int y);
        int dx = x - CX;
        int dy = y - CY;
`ifdef YX_ORDER_EN
        if (dy > 0) return 4'd5;
        if (dy < 0) return 4'd3;
        if (dx > 0) return 4'd2;
        if (dx < 0) return 4'd4;
        return 4'd1;
`else
        if (dx > 0) return 4'd2;
        if (dx < 0) return 4'd4;
        if (dy > 0) return 4'd5;
        if (dy < 0) return 4'd3;
        return 4'd1;
`endif
    endfunction

    task automatic model_push(input logic [15:0] f);
        exp_t       e;
        logic [1:0] t;
        int         x, y;
        t = f[15:14];
        x = int'(f[1:0]);
        y = int'(f[3:2]);
        e.flit = f;
        e.cyc  = cyc + 1;
        e.port = 4'd0;
        e.err  = 1'b0;
        if (t == T_HDR || t == T_HT) begin
            if (x >= XN || y >= YN) begin
                e.err = 1'b1;
            end else begin
                e.port = ref_route(x, y);
                e.err  = m_busy;
                m_busy = (t == T_HDR);
                m_lock = e.port;
            end
        end else if (m_busy) begin
            e.port = m_lock;
            if (t == T_TAIL) m_busy = 1'b0;
        end else begin
            e.err = 1'b1;
        end
        sbq.push_back(e);
    endtask

    // One clock of stimulus: drive just after the edge, decide acceptance mid-cycle.
    task automatic drive_cycle(input logic v, input logic [15:0] f, input logic r);
        @(posedge clk);
        #1;
        in_valid  = v;
        in_flit   = f;
        out_ready = r;
        @(negedge clk);
        if (in_valid && in_ready) model_push(f);
    endtask

    function automatic logic [15:0] mk(input logic [1:0] t, input int x, input int y);
        logic [15:0] f;
        f = 16'h0000;
        f[15:14] = t;
        f[1:0]   = 2'(x);
        f[3:2]   = 2'(y);
        return f;
    endfunction

    function automatic logic [15:0] rand_flit();
        int          r;
        logic [15:0] f;
        r = int'($urandom_range(0, 99));
        f = 16'($urandom);
        if (r < 35)      f[15:14] = T_BODY;
        else if (r < 55) f[15:14] = T_TAIL;
        else if (r < 80) f[15:14] = T_HDR;
        else             f[15:14] = T_HT;
        return f;
    endfunction

    // Monitor: pops on the first cycle a flit appears, then checks it holds until taken.
    bit   fresh = 1'b1;
    exp_t cur;

    always @(negedge clk) begin
        if (!rst_n) begin
            fresh = 1'b1;
        end else begin
            chk("in_ready", in_ready, !out_valid || out_ready);
            if (out_valid) begin
                if (fresh) begin
                    if (sbq.size() == 0) begin
                        chk("unexpected_out", out_flit, 32'hFFFF_FFFF);
                    end else begin
                        cur = sbq.pop_front();
                        chk("flit", out_flit, cur.flit);
                        chk("port", out_port, cur.port);
                        chk("onehot", out_onehot, oh_tab[cur.port]);
                        chk("route_err", route_err, cur.err);
                        chk("latency", cyc, cur.cyc);
                    end
                    fresh = 1'b0;
                end else begin
                    chk("hold_flit", out_flit, cur.flit);
                    chk("hold_port", out_port, cur.port);
                    chk("err_pulse", route_err, 1'b0);
                end
                if (out_ready) fresh = 1'b1;
            end else begin
                fresh = 1'b1;
                chk("err_idle", route_err, 1'b0);
            end
        end
    end

    task automatic send3(input logic [15:0] f, input logic [3:0] ep, input logic ee, input string nm);
        @(posedge clk);
        #1;
        i3_valid = 1'b1;
        i3_flit  = f;
        @(posedge clk);
        #1;
        i3_valid = 1'b0;
        @(negedge clk);
        chk({nm, "_valid"}, o3_valid, 1'b1);
        chk({nm, "_port"}, o3_port, ep);
        chk({nm, "_onehot"}, o3_onehot, oh_tab[ep]);
        chk({nm, "_err"}, o3_err, ee);
        chk({nm, "_flit"}, o3_flit, f);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_flit   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        i3_flit   = '0;
        i3_valid  = 1'b0;
        o3_ready  = 1'b1;

        repeat (3) @(posedge clk);
        #2;
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_flit", out_flit, 16'h0);
        chk("rst_port", out_port, 4'd0);
        chk("rst_onehot", out_onehot, 5'd0);
        chk("rst_err", route_err, 1'b0);
        rst_n = 1'b1;

        // Packet to (3,2): east for all three flits.
        drive_cycle(1'b1, mk(T_HDR, 3, 2), 1'b1);
        drive_cycle(1'b1, mk(T_BODY, 1, 1) | 16'h0AB0, 1'b1);
        drive_cycle(1'b1, mk(T_TAIL, 0, 0) | 16'h0CD0, 1'b1);
        drive_cycle(1'b0, 16'h0, 1'b1);

        // Header to (0,0) held under backpressure for three cycles.
        drive_cycle(1'b1, mk(T_HDR, 0, 0), 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b1, mk(T_BODY, 2, 1), 1'b0);
            chk("stall_in_ready", in_ready, 1'b0);
            chk("stall_port", out_port, 4'd3);
        end
        drive_cycle(1'b1, mk(T_BODY, 2, 1), 1'b1);
        drive_cycle(1'b1, mk(T_TAIL, 1, 3), 1'b1);
        drive_cycle(1'b0, 16'h0, 1'b1);

        // Single-flit packets to every node of the mesh.
        for (int x = 0; x < XN; x++)
            for (int y = 0; y < YN; y++)
                drive_cycle(1'b1, mk(T_HT, x, y), 1'b1);

        // Orphan body, then a header interrupting an open packet.
        drive_cycle(1'b1, mk(T_BODY, 3, 3), 1'b1);
        drive_cycle(1'b1, mk(T_HDR, 3, 2), 1'b1);
        drive_cycle(1'b1, mk(T_HDR, 0, 3), 1'b1);
        drive_cycle(1'b1, mk(T_BODY, 0, 0), 1'b1);
        drive_cycle(1'b1, mk(T_TAIL, 0, 0), 1'b1);
        drive_cycle(1'b0, 16'h0, 1'b1);

        // Narrow mesh instance: x=3 lies outside it.
        send3(mk(T_HDR, 3, 2), 4'd0, 1'b1, "oom_idle");
        send3(mk(T_HDR, 2, 2), 4'd2, 1'b0, "n3_hdr");
        send3(mk(T_HDR, 3, 0), 4'd0, 1'b1, "oom_busy");
        send3(mk(T_BODY, 0, 0), 4'd2, 1'b0, "n3_body");
        send3(mk(T_TAIL, 0, 0), 4'd2, 1'b0, "n3_tail");
        send3(mk(T_BODY, 0, 0), 4'd0, 1'b1, "n3_orphan");

        // Asynchronous reset while a header is stalled on the output.
        drive_cycle(1'b1, mk(T_HDR, 3, 2), 1'b0);
        drive_cycle(1'b0, 16'h0, 1'b0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", out_valid, 1'b0);
        chk("arst_flit", out_flit, 16'h0);
        chk("arst_port", out_port, 4'd0);
        chk("arst_onehot", out_onehot, 5'd0);
        chk("arst_err", route_err, 1'b0);
        sbq.delete();
        m_busy = 1'b0;
        m_lock = 4'd0;
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive_cycle(1'b1, mk(T_BODY, 1, 1), 1'b1);
        drive_cycle(1'b0, 16'h0, 1'b1);

        // Randomized traffic with random backpressure.
        for (int i = 0; i < 3000; i++)
            drive_cycle($urandom_range(0, 3) != 0, rand_flit(), $urandom_range(0, 9) < 7);

        drive_cycle(1'b0, 16'h0, 1'b1);
        for (int i = 0; i < 50 && sbq.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        chk("drain_empty", sbq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", nchk, nerr);
        $finish;
    end

endmodule
